// File: rtl/reaction_timer_core_if.sv
// reaction_timer_core_if
//   Groups the control pulses and result outputs of the reaction timer.
//   master modport: the board/test side, drives start/stop/clr_best and
//                   observes the results.
//   slave  modport: the reaction_timer_core side.
//   Signals:
//     start, stop, clr_best : one-cycle pulses into the core
//     ledr                  : LED countdown bar (N_LEDS)
//     reaction_ms, best_ms  : last and best result (COUNT_W)
//     best_valid            : best_ms holds a real result
//     busy, done, false_start : status flags
interface reaction_timer_core_if #(
   parameter int N_LEDS  = 10,
   parameter int COUNT_W = 16
) ();
   logic               start;
   logic               stop;
   logic               clr_best;
   logic [N_LEDS-1:0]  ledr;
   logic [COUNT_W-1:0] reaction_ms;
   logic [COUNT_W-1:0] best_ms;
   logic               best_valid;
   logic               busy;
   logic               done;
   logic               false_start;

   modport master (
      output start, stop, clr_best,
      input  ledr, reaction_ms, best_ms, best_valid, busy, done, false_start
   );

   modport slave (
      input  start, stop, clr_best,
      output ledr, reaction_ms, best_ms, best_valid, busy, done, false_start
   );
endinterface

// File: rtl/reaction_timer_core.sv
// reaction_timer_core
//   Reaction-timer engine: ms tick divider, LED countdown bar, LFSR random
//   delay, reaction counter with saturation, false-start detection and a
//   best-time register. All outputs are registered.
//   Ports:
//     clk   : single clock
//     rst_n : synchronous active-low reset
//     bus   : reaction_timer_core_if.slave (start/stop/clr_best in,
//             ledr/reaction_ms/best_ms/best_valid/busy/done/false_start out)
//   N_LEDS must be at least 2; CLK_PER_MS must be at least 2.
module reaction_timer_core #(
   parameter int                CLK_PER_MS   = 50000,
   parameter int                N_LEDS       = 10,
   parameter int                STEP_MS      = 500,
   parameter int                LFSR_W       = 14,
   parameter logic [LFSR_W-1:0] TAPS         = 14'h3802,
   parameter int                MIN_DELAY_MS = 1000,
   parameter int                COUNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   reaction_timer_core_if.slave  bus
);

   localparam int DIV_W  = $clog2(CLK_PER_MS);
   localparam int STEP_W = $clog2(STEP_MS + 1);
   localparam int DLY_W  = LFSR_W + 1;
   // One ms counter serves both the LED step and the random delay.
   localparam int MS_W   = (DLY_W > STEP_W) ? DLY_W : STEP_W;

   localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_PER_MS - 1);
   localparam logic [MS_W-1:0]    STEP_LAST = MS_W'(STEP_MS - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LIGHTS = 3'd1,
      S_DELAY  = 3'd2,
      S_TIMING = 3'd3,
      S_DONE   = 3'd4,
      S_FOUL   = 3'd5
   } state_t;

   state_t               state_r, state_nxt_s;
   logic [DIV_W-1:0]     div_r, div_nxt_s;
   logic [MS_W-1:0]      ms_cnt_r, ms_nxt_s;
   logic [DLY_W-1:0]     delay_ms_r, delay_nxt_s;
   logic [LFSR_W-1:0]    lfsr_r;
   logic [COUNT_W-1:0]   cnt_r, cnt_nxt_s;
   logic [COUNT_W-1:0]   reaction_r, reaction_nxt_s;
   logic [COUNT_W-1:0]   best_r, best_nxt_s;
   logic                 valid_r, valid_nxt_s;
   logic [N_LEDS-1:0]    ledr_r, ledr_nxt_s;
   logic [N_LEDS-1:0]    ledr_shift_s;
   logic                 busy_r, done_r, foul_r;
   logic                 busy_nxt_s, done_nxt_s, foul_nxt_s;
   logic                 tick_s;
   logic [MS_W-1:0]      delay_last_s;

   // Fibonacci LFSR step; a non-zero seed never reaches all zeros.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      lfsr_next = {q[LFSR_W-2:0], ^(q & TAPS)};
   endfunction

   assign tick_s       = (div_r == DIV_LAST);
   assign ledr_shift_s = {1'b1, ledr_r[N_LEDS-1:1]};
   assign delay_last_s = MS_W'(delay_ms_r) - MS_W'(1);

   // Next-state, datapath and output-flag decode
   always_comb begin
      state_nxt_s    = state_r;
      ledr_nxt_s     = ledr_r;
      ms_nxt_s       = ms_cnt_r;
      cnt_nxt_s      = cnt_r;
      delay_nxt_s    = delay_ms_r;
      reaction_nxt_s = reaction_r;
      best_nxt_s     = best_r;
      valid_nxt_s    = valid_r;
      div_nxt_s      = div_r;

      case (state_r)
         S_IDLE, S_DONE, S_FOUL: begin
            if (bus.start) begin
               state_nxt_s = S_LIGHTS;
               ledr_nxt_s  = {N_LEDS{1'b0}};
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_LIGHTS: begin
            if (bus.stop) begin
               state_nxt_s = S_FOUL;
               ledr_nxt_s  = {N_LEDS{1'b0}};
            end else if (tick_s) begin
               if (ms_cnt_r == STEP_LAST) begin
                  ms_nxt_s   = {MS_W{1'b0}};
                  ledr_nxt_s = ledr_shift_s;
                  // The bar is full exactly after N_LEDS steps.
                  if (&ledr_shift_s) begin
                     state_nxt_s = S_DELAY;
                     delay_nxt_s = DLY_W'(MIN_DELAY_MS) + {1'b0, lfsr_r};
                  end else begin
                     state_nxt_s = S_LIGHTS;
                  end
               end else begin
                  ms_nxt_s = ms_cnt_r + MS_W'(1);
               end
            end else begin
               state_nxt_s = S_LIGHTS;
            end
         end
         S_DELAY: begin
            if (bus.stop) begin
               state_nxt_s = S_FOUL;
               ledr_nxt_s  = {N_LEDS{1'b0}};
            end else if (tick_s) begin
               if (ms_cnt_r == delay_last_s) begin
                  state_nxt_s = S_TIMING;
                  ledr_nxt_s  = {N_LEDS{1'b0}};
                  cnt_nxt_s   = {COUNT_W{1'b0}};
               end else begin
                  ms_nxt_s = ms_cnt_r + MS_W'(1);
               end
            end else begin
               state_nxt_s = S_DELAY;
            end
         end
         S_TIMING: begin
            if (bus.stop) begin
               // Latch the value before any same-cycle tick increment.
               state_nxt_s    = S_DONE;
               reaction_nxt_s = cnt_r;
               if (!valid_r || (cnt_r < best_r)) begin
                  best_nxt_s  = cnt_r;
                  valid_nxt_s = 1'b1;
               end else begin
                  best_nxt_s  = best_r;
               end
            end else if (cnt_r == COUNT_MAX) begin
               state_nxt_s    = S_DONE;
               reaction_nxt_s = COUNT_MAX;
            end else if (tick_s) begin
               cnt_nxt_s = cnt_r + COUNT_W'(1);
            end else begin
               state_nxt_s = S_TIMING;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            ledr_nxt_s  = {N_LEDS{1'b0}};
         end
      endcase

      // Clearing the best time overrides any same-cycle update.
      if (bus.clr_best) begin
         best_nxt_s  = COUNT_MAX;
         valid_nxt_s = 1'b0;
      end else begin
         valid_nxt_s = valid_nxt_s;
      end

      // Divider and ms counter restart on every state entry.
      if (state_nxt_s != state_r) begin
         div_nxt_s = {DIV_W{1'b0}};
         ms_nxt_s  = {MS_W{1'b0}};
      end else if (tick_s) begin
         div_nxt_s = {DIV_W{1'b0}};
      end else begin
         div_nxt_s = div_r + DIV_W'(1);
      end

      busy_nxt_s = (state_nxt_s == S_LIGHTS) || (state_nxt_s == S_DELAY) ||
                   (state_nxt_s == S_TIMING);
      done_nxt_s = (state_nxt_s == S_DONE);
      foul_nxt_s = (state_nxt_s == S_FOUL);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath and registered output flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_r      <= {DIV_W{1'b0}};
         ms_cnt_r   <= {MS_W{1'b0}};
         delay_ms_r <= {DLY_W{1'b0}};
         cnt_r      <= {COUNT_W{1'b0}};
         reaction_r <= {COUNT_W{1'b0}};
         best_r     <= COUNT_MAX;
         valid_r    <= 1'b0;
         ledr_r     <= {N_LEDS{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         foul_r     <= 1'b0;
      end else begin
         div_r      <= div_nxt_s;
         ms_cnt_r   <= ms_nxt_s;
         delay_ms_r <= delay_nxt_s;
         cnt_r      <= cnt_nxt_s;
         reaction_r <= reaction_nxt_s;
         best_r     <= best_nxt_s;
         valid_r    <= valid_nxt_s;
         ledr_r     <= ledr_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         foul_r     <= foul_nxt_s;
      end
   end

   // Free-running random source, advances in every state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_r <= {LFSR_W{1'b1}};
      end else begin
         lfsr_r <= lfsr_next(lfsr_r);
      end
   end

   assign bus.ledr        = ledr_r;
   assign bus.reaction_ms = reaction_r;
   assign bus.best_ms     = best_r;
   assign bus.best_valid  = valid_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.false_start = foul_r;

endmodule

// File: doc/reaction_timer_core.md
# reaction_timer_core

Parametrised single-clock reaction-timer engine for the next board revision. It generalises the tick, LED-sequence FSM, LFSR delay and reaction-counter chain into one block with configurable tick rate, LED count, delay range and counter width. It adds false-start detection, a saturating timeout and a best-time register. The board top instantiates it and feeds `reaction_ms` and `best_ms` into the existing binary-to-BCD and 7-segment path.

## Interface
- `CLK_PER_MS`, default 50000: clk cycles per ms tick; must be ≥ 2.
- `N_LEDS`, default 10: width of the LED countdown bar.
- `STEP_MS`, default 500: ms between successive LEDs lighting.
- `LFSR_W`, default 14: LFSR width.
- `TAPS`, default 14'h3802: Fibonacci feedback mask (bits 13, 12, 11, 1).
- `MIN_DELAY_MS`, default 1000: fixed part of the random delay.
- `COUNT_W`, default 16: width of the reaction and best counters.

- `clk` input, 1: single clock, all logic rises on it.
- `rst_n` input, 1: reset is synchronous and active-low.
- `start` input, 1: one-cycle pulse, already synchronised and debounced.
- `stop` input, 1: one-cycle reaction pulse, same conditioning as `start`.
- `clr_best` input, 1: one-cycle pulse that invalidates the best time.
- `ledr` output, N_LEDS: countdown bar.
- `reaction_ms` output, COUNT_W: last valid result.
- `best_ms` output, COUNT_W: minimum valid result.
- `best_valid` output, 1: `best_ms` holds a real result.
- `busy` output, 1: high in LIGHTS, DELAY and TIMING.
- `done` output, 1: high in DONE.
- `false_start` output, 1: high in FOUL.

## Operation
- **Reset values:** state IDLE; `ledr` 0; `reaction_ms` 0; `best_ms` all ones; `best_valid` 0; `busy`, `done` and `false_start` 0; LFSR all ones; divider 0.
- **ms divider:**
  - Counts 0 to CLK_PER_MS-1 and wraps.
  - `tick` is high in the cycle the divider equals CLK_PER_MS-1.
  - The divider clears to 0 on every state entry.
- **LFSR:**
  - Advances every clk cycle in every state.
  - Next value is `{q[LFSR_W-2:0], ^(q & TAPS)}`.
  - It never reaches the all-zero state.
- **IDLE:** `start` moves to LIGHTS. `stop` is ignored.
- **LIGHTS:**
  - On entry, `ledr` is 0 and the step counter is 0.
  - After every STEP_MS ticks, shift a 1 in from the MSB. After k steps, the top k LEDs are lit.
  - After N_LEDS steps (`ledr` all ones), move to DELAY.
  - At that transition, latch `delay_ms = MIN_DELAY_MS + lfsr`, width LFSR_W+1.
- **DELAY:**
  - `ledr` stays all ones.
  - Count ticks; when the count reaches `delay_ms`, move to TIMING ("go").
  - At go, clear `ledr` to 0 and the timing counter to 0.
- **TIMING:**
  - Each tick increments the timing counter.
  - `stop` moves to DONE and latches the timing counter value from before any same-cycle increment into `reaction_ms`.
  - If `reaction_ms < best_ms` or `best_valid` is 0, load `best_ms` and set `best_valid`.
  - When the counter reaches 2^COUNT_W-1 (saturation), move to DONE with `reaction_ms` = all ones. `best_ms` is not updated in this case.
- **False start:** `stop` in LIGHTS or DELAY moves to FOUL. `ledr` goes to 0 and `reaction_ms` and `best_ms` are unchanged.
- **DONE / FOUL:** held until `start`, which moves to LIGHTS.
- **Ignored inputs:** `start` is ignored in LIGHTS, DELAY and TIMING.
- **Simultaneous events:**
  - `start` and `stop` together: in TIMING, `stop` wins; in IDLE, DONE and FOUL, `start` wins.
  - `clr_best` sets `best_valid` to 0 and `best_ms` to all ones. It has priority over a same-cycle best update.
- **Reset mid-operation:** `rst_n` low in any state restores all reset values at the next edge, including `best_ms`.

## Timing
- Every output is registered and changes on the edge after its cause.
- `start` sampled at cycle T: state is LIGHTS and `busy` is 1 from T+1. This entry cycle is E.
- LED k (k = 1..N_LEDS) lights at E + k·STEP_MS·CLK_PER_MS.
- DELAY is entered at E + N_LEDS·STEP_MS·CLK_PER_MS; call that cycle D.
- Go (`ledr` 0, state TIMING) occurs at cycle G = D + delay_ms·CLK_PER_MS.
- `stop` sampled at cycle S in TIMING: `reaction_ms` = floor((S−G)/CLK_PER_MS).
- `done` and `reaction_ms` update at S+1.
- `stop` in LIGHTS or DELAY: `false_start` rises at the next cycle and `busy` falls in the same cycle.

## Test plan
Unless a scenario says otherwise, use CLK_PER_MS=4, N_LEDS=4, STEP_MS=2, LFSR_W=4, TAPS=4'hC, MIN_DELAY_MS=3 and COUNT_W=8.

- **Reset:** hold `rst_n` low 3 cycles, then release. All outputs hold reset values; `best_ms` is 8'hFF and `ledr` is 0. The LFSR follows F, E, C, 8, 1, 2, … (period 15).
- **LED bar:** `start` at T. `ledr` reads 4'b1000, 1100, 1110 and 1111 at T+1+8k for k = 1..4. DELAY is entered at T+33 with `delay_ms` equal to the model LFSR value + 3.
- **Normal run:** `stop` 22 cycles after go. Result is `reaction_ms`=5, `best_ms`=5, `best_valid`=1 and `done`=1. A second run with a 10 ms result leaves `best_ms`=5. A third run with a 2 ms result sets `best_ms`=2.
- **False start:** `stop` during LIGHTS, and separately during DELAY. Each gives `false_start`=1, `ledr`=0 and `reaction_ms` and `best_ms` unchanged. A following `start` restarts LIGHTS.
- **Saturation and priority:** COUNT_W=4, no `stop`: DONE is reached with `reaction_ms`=4'hF and `best_ms` is not updated. `start` and `stop` together in TIMING give DONE. `clr_best` in the same cycle as a best update leaves `best_valid`=0.
- **Reset mid-DELAY:** pulse `rst_n` low during DELAY. State returns to IDLE and `ledr`=0 at the next edge, and `best_valid` clears.
